mem_access_unit: RTL and testbench

- Initiator-side memory access unit for the MEM stage of the RV32IM pipeline.
- Accepts load/store requests from the pipeline and drives the data memory's READ/WRITE/FUNCT3/ADDRESS/WRITEDATA strobes for a fixed latency window, then releases them.
- Formats load data (byte/half/word, signed/unsigned) and stalls the pipeline until the access completes.

---
 rtl/mem_access_unit_if.sv | 44 ++++
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Bundles the pipeline request/response signals and the data
//             memory strobe/response signals of mem_access_unit.
//  Modports : master - the access unit (drives strobes, load data, stall)
//             slave  - pipeline plus data memory environment
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    // Pipeline side
    logic        REQ_READ;
    logic        REQ_WRITE;
    logic [2:0]  REQ_FUNCT3;
    logic [31:0] REQ_ADDRESS;
    logic [31:0] REQ_WRITEDATA;
    logic [31:0] LOAD_DATA;
    logic        STALL;
    logic        DONE;
    logic        MISALIGNED;
    // Data memory side
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport master (
        input  REQ_READ, REQ_WRITE, REQ_FUNCT3, REQ_ADDRESS, REQ_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT,
        output LOAD_DATA, STALL, DONE, MISALIGNED,
        output MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport slave (
        output REQ_READ, REQ_WRITE, REQ_FUNCT3, REQ_ADDRESS, REQ_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT,
        input  LOAD_DATA, STALL, DONE, MISALIGNED,
        input  MEM_READ, MEM_WRITE, MEM_FUNCT3, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage initiator for the RV32IM data memory. Latches a
//             load/store request, holds the memory strobe for MEM_LATENCY
//             cycles, formats load data and stalls the pipeline until done.
//  Ports    : CLK, RESET (sync, active-high)
//             bus (mem_access_unit_if.master): REQ_* from pipeline,
//             LOAD_DATA/STALL/DONE/MISALIGNED to pipeline, MEM_* to memory
//  Options  : MAU_MISALIGN_CHECK_EN - reject misaligned half/word accesses
//             (no strobe, MISALIGNED pulse with DONE). Undefined: MISALIGNED
//             is tied low and the raw address is used.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int MEM_LATENCY = 6   // strobe hold cycles, 1..255
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    mem_access_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] c_COUNT_INIT = 8'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_count;
    logic        r_is_load;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_done;
    logic        r_misaligned;
    logic [31:0] r_load_data;
    logic [2:0]  r_funct3;
    logic [31:0] r_address;
    logic [31:0] r_writedata;

    logic        w_req;
    logic        w_store_f3_ok;
    logic        w_misaligned;
    logic        w_skip;
    logic [7:0]  w_b0, w_b1, w_b2, w_b3;
    logic [31:0] w_load_fmt;

    // A simultaneous read+write request is a store.
    assign w_req         = bus.REQ_READ | bus.REQ_WRITE;
    assign w_store_f3_ok = (bus.REQ_FUNCT3 == 3'b000) || (bus.REQ_FUNCT3 == 3'b001) ||
                           (bus.REQ_FUNCT3 == 3'b010);

`ifdef MAU_MISALIGN_CHECK_EN
    logic w_half;
    logic w_word;
    // 101 is only a halfword for loads (LHU); for stores it is illegal anyway.
    assign w_half       = (bus.REQ_FUNCT3 == 3'b001) ||
                          (!bus.REQ_WRITE && (bus.REQ_FUNCT3 == 3'b101));
    assign w_word       = (bus.REQ_FUNCT3 == 3'b010);
    assign w_misaligned = (w_half && bus.REQ_ADDRESS[0]) ||
                          (w_word && (bus.REQ_ADDRESS[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // Requests that never touch memory go straight to DONE.
    assign w_skip = (bus.REQ_WRITE && !w_store_f3_ok) || w_misaligned;

    // Byte lanes: b0 is the byte at the address and the least significant.
    assign w_b0 = bus.MEM_READDATA[31:24];
    assign w_b1 = bus.MEM_READDATA[23:16];
    assign w_b2 = bus.MEM_READDATA[15:8];
    assign w_b3 = bus.MEM_READDATA[7:0];

    always_comb begin
        w_load_fmt = 32'd0;
        case (r_funct3)
            3'b000:  w_load_fmt = {{24{w_b0[7]}}, w_b0};
            3'b100:  w_load_fmt = {24'd0, w_b0};
            3'b001:  w_load_fmt = {{16{w_b1[7]}}, w_b1, w_b0};
            3'b101:  w_load_fmt = {16'd0, w_b1, w_b0};
            3'b010:  w_load_fmt = {w_b3, w_b2, w_b1, w_b0};
            default: w_load_fmt = 32'd0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_req) w_state_next = w_skip ? S_DONE : S_ACCESS;
            S_ACCESS:  if (r_count == 8'd0) w_state_next = S_RELEASE;
            S_RELEASE: if (!bus.MEM_BUSYWAIT) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_count      <= 8'd0;
            r_is_load    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_load_data  <= 32'd0;
            r_funct3     <= 3'd0;
            r_address    <= 32'd0;
            r_writedata  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_funct3    <= bus.REQ_FUNCT3;
                        r_address   <= bus.REQ_ADDRESS;
                        r_writedata <= bus.REQ_WRITEDATA;
                        r_is_load   <= !bus.REQ_WRITE;
                        r_count     <= c_COUNT_INIT;
                        if (w_skip) begin
                            r_misaligned <= w_misaligned;
                            if (w_misaligned) r_load_data <= 32'd0;
                        end else begin
                            r_mem_read  <= !bus.REQ_WRITE;
                            r_mem_write <= bus.REQ_WRITE;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_count == 8'd0) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (r_is_load) r_load_data <= w_load_fmt;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                S_DONE:  r_misaligned <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.STALL = !RESET && (((r_state == S_IDLE) && w_req) ||
                                  (r_state == S_ACCESS) || (r_state == S_RELEASE));
    assign bus.LOAD_DATA     = r_load_data;
    assign bus.DONE          = r_done;
    assign bus.MISALIGNED    = r_misaligned;
    assign bus.MEM_READ      = r_mem_read;
    assign bus.MEM_WRITE     = r_mem_write;
    assign bus.MEM_FUNCT3    = r_funct3;
    assign bus.MEM_ADDRESS   = r_address;
    assign bus.MEM_WRITEDATA = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit with a small
//             byte-array data memory model. Honours MAU_MISALIGN_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int L = 6;

    logic clk;
    logic rst;
    logic force_busy;
    logic pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_word;
    logic [7:0]  mem [0:255];

    int checks;
    int errors;

    // Results of the most recent access
    int   res_first, res_last, res_rd, res_wr, res_stall, res_done, res_unstable;
    logic res_mis;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_LATENCY(L)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: lane [31:24] is the byte at the address.
    logic [7:0] ma0, ma1, ma2, ma3;
    assign ma0 = bus.MEM_ADDRESS[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;
    assign bus.MEM_READDATA = {mem[ma0], mem[ma1], mem[ma2], mem[ma3]};
    assign bus.MEM_BUSYWAIT = bus.MEM_READ | bus.MEM_WRITE | force_busy;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr]         <= pre_word[31:24];
            mem[pre_addr + 8'd1]  <= pre_word[23:16];
            mem[pre_addr + 8'd2]  <= pre_word[15:8];
            mem[pre_addr + 8'd3]  <= pre_word[7:0];
        end else if (bus.MEM_WRITE) begin
            mem[ma0] <= bus.MEM_WRITEDATA[7:0];
            if (bus.MEM_FUNCT3 == 3'b001 || bus.MEM_FUNCT3 == 3'b010)
                mem[ma1] <= bus.MEM_WRITEDATA[15:8];
            if (bus.MEM_FUNCT3 == 3'b010) begin
                mem[ma2] <= bus.MEM_WRITEDATA[23:16];
                mem[ma3] <= bus.MEM_WRITEDATA[31:24];
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Writes a word in lane order (w[31:24] lands at addr).
    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_word = w;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Presents a request in cycle 0 and observes each cycle until DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int busy_extra);
        res_first = -1; res_last = -1; res_rd = 0; res_wr = 0;
        res_stall = 0; res_done = -1; res_unstable = 0; res_mis = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 40 && res_done < 0; c++) begin
            if (c == 0) begin
                bus.REQ_READ      = rd;
                bus.REQ_WRITE     = wr;
                bus.REQ_FUNCT3    = f3;
                bus.REQ_ADDRESS   = addr;
                bus.REQ_WRITEDATA = wd;
            end else if (c == 1) begin
                bus.REQ_READ  = 1'b0;
                bus.REQ_WRITE = 1'b0;
            end
            force_busy = (busy_extra > 0) && (c >= 1) && (c <= L + busy_extra);
            #1;
            if (bus.MEM_READ || bus.MEM_WRITE) begin
                if (res_first < 0) res_first = c;
                res_last = c;
                if (bus.MEM_ADDRESS !== addr || bus.MEM_FUNCT3 !== f3 ||
                    bus.MEM_WRITEDATA !== wd) res_unstable++;
            end
            if (bus.MEM_READ)  res_rd++;
            if (bus.MEM_WRITE) res_wr++;
            if (bus.STALL)     res_stall++;
            if (bus.DONE) begin
                res_done = c;
                res_mis  = bus.MISALIGNED;
            end
            if (res_done < 0) @(negedge clk);
        end
        force_busy = 1'b0;
    endtask

    task automatic expect_timing(input string tag, input int exp_rd, input int exp_wr,
                                 input int exp_stall, input int exp_done);
        check_value({tag, " read_cycles"},  32'(res_rd), 32'(exp_rd));
        check_value({tag, " write_cycles"}, 32'(res_wr), 32'(exp_wr));
        check_value({tag, " stall_cycles"}, 32'(res_stall), 32'(exp_stall));
        check_value({tag, " done_cycle"},   32'(res_done), 32'(exp_done));
        check_value({tag, " misaligned"},   {31'd0, res_mis}, 32'd0);
        if (exp_rd + exp_wr > 0) begin
            check_value({tag, " first_strobe"}, 32'(res_first), 32'd1);
            check_value({tag, " last_strobe"},  32'(res_last), 32'(L));
            check_value({tag, " latched_stable"}, 32'(res_unstable), 32'd0);
        end
    endtask

    initial begin
        int n_done, n_stall, n_strobe;
        checks = 0; errors = 0;
        rst = 1'b1; force_busy = 1'b0; pre_we = 1'b0; pre_addr = 8'd0; pre_word = 32'd0;
        bus.REQ_READ = 1'b0; bus.REQ_WRITE = 1'b0; bus.REQ_FUNCT3 = 3'd0;
        bus.REQ_ADDRESS = 32'd0; bus.REQ_WRITEDATA = 32'd0;

        // Reset values; a request during reset must not raise STALL
        repeat (3) @(negedge clk);
        bus.REQ_READ = 1'b1;
        #1;
        check_value("rst STALL",         {31'd0, bus.STALL}, 32'd0);
        check_value("rst LOAD_DATA",     bus.LOAD_DATA, 32'd0);
        check_value("rst DONE",          {31'd0, bus.DONE}, 32'd0);
        check_value("rst MISALIGNED",    {31'd0, bus.MISALIGNED}, 32'd0);
        check_value("rst MEM_READ",      {31'd0, bus.MEM_READ}, 32'd0);
        check_value("rst MEM_WRITE",     {31'd0, bus.MEM_WRITE}, 32'd0);
        check_value("rst MEM_FUNCT3",    {29'd0, bus.MEM_FUNCT3}, 32'd0);
        check_value("rst MEM_ADDRESS",   bus.MEM_ADDRESS, 32'd0);
        check_value("rst MEM_WRITEDATA", bus.MEM_WRITEDATA, 32'd0);
        bus.REQ_READ = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Loads
        preload(8'h10, 32'h78563412);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0);
        expect_timing("LW", L, 0, L + 2, L + 2);
        check_value("LW data", bus.LOAD_DATA, 32'h12345678);

        preload(8'h20, 32'h80AABBCC);
        do_access(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 0);
        expect_timing("LB", L, 0, L + 2, L + 2);
        check_value("LB data", bus.LOAD_DATA, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 0);
        check_value("LBU data", bus.LOAD_DATA, 32'h00000080);

        preload(8'h20, 32'h01F05566);
        do_access(1'b1, 1'b0, 3'b001, 32'h20, 32'h0, 0);
        check_value("LH data", bus.LOAD_DATA, 32'hFFFFF001);
        do_access(1'b1, 1'b0, 3'b101, 32'h20, 32'h0, 0);
        check_value("LHU data", bus.LOAD_DATA, 32'h0000F001);

        // Store and read-back
        do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 0);
        expect_timing("SW", 0, L, L + 2, L + 2);
        check_value("SW load_data_kept", bus.LOAD_DATA, 32'h0000F001);
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0);
        check_value("LW readback", bus.LOAD_DATA, 32'hDEADBEEF);

        // Busy memory holds RELEASE three more cycles
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 3);
        expect_timing("LW busy", L, 0, L + 5, L + 5);
        check_value("LW busy data", bus.LOAD_DATA, 32'h12345678);

        // Illegal store funct3: no strobe, straight to DONE
        do_access(1'b0, 1'b1, 3'b011, 32'h40, 32'h11111111, 0);
        expect_timing("bad store", 0, 0, 1, 1);
        check_value("bad store load_data", bus.LOAD_DATA, 32'h12345678);

        // Read+write together is a store
        do_access(1'b1, 1'b1, 3'b000, 32'h50, 32'h123456A5, 0);
        expect_timing("rd+wr", 0, L, L + 2, L + 2);
        check_value("rd+wr load_data", bus.LOAD_DATA, 32'h12345678);
        do_access(1'b1, 1'b0, 3'b100, 32'h50, 32'h0, 0);
        check_value("SB readback", bus.LOAD_DATA, 32'h000000A5);

        // Unknown load funct3: access happens, result 0
        do_access(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 0);
        expect_timing("bad load", L, 0, L + 2, L + 2);
        check_value("bad load data", bus.LOAD_DATA, 32'h0);

        // Misaligned word load
        preload(8'h44, 32'h11000000);
        do_access(1'b1, 1'b0, 3'b010, 32'h41, 32'h0, 0);
`ifdef MAU_MISALIGN_CHECK_EN
        check_value("mis strobes", 32'(res_rd + res_wr), 32'd0);
        check_value("mis done_cycle", 32'(res_done), 32'd1);
        check_value("mis flag", {31'd0, res_mis}, 32'd1);
        check_value("mis load_data", bus.LOAD_DATA, 32'h0);
`else
        expect_timing("unaligned LW", L, 0, L + 2, L + 2);
        check_value("unaligned LW data", bus.LOAD_DATA, 32'h11DEADBE);
`endif

        // Reset in the middle of an access
        @(negedge clk);
        bus.REQ_READ = 1'b1; bus.REQ_FUNCT3 = 3'b010; bus.REQ_ADDRESS = 32'h10;
        @(negedge clk);
        bus.REQ_READ = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_value("pre-reset MEM_READ", {31'd0, bus.MEM_READ}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_value("mid-reset MEM_READ", {31'd0, bus.MEM_READ}, 32'd0);
        check_value("mid-reset STALL", {31'd0, bus.STALL}, 32'd0);
        rst = 1'b0;
        n_done = 0; n_stall = 0; n_strobe = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            if (bus.DONE) n_done++;
            if (bus.STALL) n_stall++;
            if (bus.MEM_READ || bus.MEM_WRITE) n_strobe++;
        end
        check_value("post-reset DONE", 32'(n_done), 32'd0);
        check_value("post-reset STALL", 32'(n_stall), 32'd0);
        check_value("post-reset strobe", 32'(n_strobe), 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0);
        expect_timing("LW after reset", L, 0, L + 2, L + 2);
        check_value("LW after reset data", bus.LOAD_DATA, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
